counter_div_prog: RTL and testbench

//  Programmable terminal-count counter used to sequence multi-cycle datapath

---
 rtl/counter_div_prog.sv | 189 ++++++++++++++++++
 tb/tb_counter_div_prog.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_div_prog.sv
//============================================================================
// Module      : counter_div_prog
// Description : Programmable terminal-count counter (up/down, one-shot or
//               auto-reload). Optional prescaler: COUNTER_DIV_PRESCALE_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module counter_div_prog #(
    parameter int WIDTH      = 16,
    parameter int RELOAD_DEF = 15,
    parameter int PRE_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             mode_auto,
`ifdef COUNTER_DIV_PRESCALE_EN
    input  logic [PRE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_RESET = WIDTH'(RELOAD_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_load;
    logic             r_dir;
    logic             r_auto;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_capture;
    logic             w_pre_clr;
    logic             w_tick;
    logic [WIDTH-1:0] w_new_start;
    logic [WIDTH-1:0] w_run_start;
    logic [WIDTH-1:0] w_run_term;
    logic             w_at_term;

    // Start value for a fresh run comes from the live inputs; the running
    // range comes from the configuration captured at start.
    assign w_new_start = dir   ? '0     : load_val;
    assign w_run_start = r_dir ? '0     : r_load;
    assign w_run_term  = r_dir ? r_load : '0;
    assign w_at_term   = (r_count == w_run_term);

`ifdef COUNTER_DIV_PRESCALE_EN
    logic [PRE_W-1:0] r_pre_cnt;
    logic [PRE_W-1:0] r_pre_val;

    localparam logic [PRE_W-1:0] c_PRE_ONE = PRE_W'(1);

    assign w_tick = enb && (r_pre_cnt == r_pre_val);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre_cnt <= '0;
            r_pre_val <= '0;
        end else if (w_pre_clr) begin
            r_pre_cnt <= '0;
            if (w_capture) begin
                r_pre_val <= prescale;
            end
        end else if (r_state == ST_RUN && enb) begin
            r_pre_cnt <= (r_pre_cnt == r_pre_val) ? '0 : r_pre_cnt + c_PRE_ONE;
        end
    end
`else
    logic [PRE_W-1:0] w_unused_pre;

    assign w_unused_pre = {PRE_W{w_pre_clr}};
    assign w_tick       = enb;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority within a cycle: stop, then start, then tick.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_ovf_nxt   = 1'b0;
        w_done_nxt  = r_done;
        w_capture   = 1'b0;
        w_pre_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (stop) begin
                    w_pre_clr = 1'b1;
                end else if (start) begin
                    w_capture   = 1'b1;
                    w_pre_clr   = 1'b1;
                    w_count_nxt = w_new_start;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_pre_clr   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_capture   = 1'b1;
                    w_pre_clr   = 1'b1;
                    w_count_nxt = w_new_start;
                    w_done_nxt  = 1'b0;
                end else if (w_tick) begin
                    if (w_at_term) begin
                        w_ovf_nxt   = 1'b1;
                        w_count_nxt = w_run_start;
                        if (!r_auto) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_count_nxt = r_dir ? r_count + c_ONE : r_count - c_ONE;
                    end
                end
            end
            ST_DONE: begin
                if (stop) begin
                    w_pre_clr   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_capture   = 1'b1;
                    w_pre_clr   = 1'b1;
                    w_count_nxt = w_new_start;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= c_RESET;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_load  <= '0;
            r_dir   <= 1'b0;
            r_auto  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_done  <= w_done_nxt;
            if (w_capture) begin
                r_load <= load_val;
                r_dir  <= dir;
                r_auto <= mode_auto;
            end
        end
    end

    assign count = r_count;
    assign ovf   = r_ovf;
    assign busy  = (r_state == ST_RUN);
    assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_counter_div_prog.sv
//============================================================================
// Module      : tb_counter_div_prog
// Description : Self-checking bench for counter_div_prog with a behavioural
//               reference model (period position instead of count value).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_counter_div_prog;

    localparam int WIDTH = 16;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             enb       = 1'b0;
    logic             start     = 1'b0;
    logic             stop      = 1'b0;
    logic [WIDTH-1:0] load_val  = '0;
    logic             dir       = 1'b0;
    logic             mode_auto = 1'b0;
`ifdef COUNTER_DIV_PRESCALE_EN
    logic [3:0]       prescale  = '0;
`endif
    logic [WIDTH-1:0] count;
    logic             ovf;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    counter_div_prog #(
        .WIDTH      (WIDTH),
        .RELOAD_DEF (15),
        .PRE_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .start     (start),
        .stop      (stop),
        .load_val  (load_val),
        .dir       (dir),
        .mode_auto (mode_auto),
`ifdef COUNTER_DIV_PRESCALE_EN
        .prescale  (prescale),
`endif
        .count     (count),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model: a run is a position within the period 0..load.
    bit m_run, m_done, m_dir, m_auto, m_ovf;
    int m_load, m_pos, m_hold, m_pre, m_pcnt;

    function automatic int m_count();
        if (m_run) return m_dir ? m_pos : (m_load - m_pos);
        return m_hold;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_dir = 0; m_auto = 0; m_ovf = 0;
        m_load = 0; m_pos = 0; m_hold = 15; m_pre = 0; m_pcnt = 0;
    endtask

    task automatic model_step();
        int pre_in;
        pre_in = 0;
`ifdef COUNTER_DIV_PRESCALE_EN
        pre_in = int'(prescale);
`endif
        m_ovf = 0;
        if (stop) begin
            if (m_run) m_hold = m_count();
            m_run = 0;
        end else if (start) begin
            m_run = 1; m_done = 0;
            m_load = int'(load_val); m_dir = dir; m_auto = mode_auto;
            m_pre = pre_in; m_pos = 0; m_pcnt = 0;
        end else if (m_run && enb) begin
            m_pcnt++;
            if (m_pcnt > m_pre) begin
                m_pcnt = 0;
                if (m_pos == m_load) begin
                    m_ovf = 1;
                    m_pos = 0;
                    if (!m_auto) begin
                        m_run  = 0;
                        m_done = 1;
                        m_hold = m_dir ? 0 : m_load;
                    end
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic begin_run(input int lv, input bit d, input bit a);
        load_val = WIDTH'(lv); dir = d; mode_auto = a; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({count, ovf, busy, done} !== {16'd15, 3'b000}) begin
            errors++;
            $display("FAIL reset_init got count=%0d ovf=%0b busy=%0b done=%0b want 15/0/0/0",
                     count, ovf, busy, done);
        end
        rst = 1'b1;
        enb = 1'b1;
        begin_run(15, 1'b0, 1'b1);
        repeat (6) cyc();
        checks++;
        if (count !== 16'd9) begin
            errors++;
            $display("FAIL reset_prep got count=%0d want 9", count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({count, ovf, busy, done} !== {16'd15, 3'b000}) begin
            errors++;
            $display("FAIL reset_midrun got count=%0d ovf=%0b busy=%0b done=%0b want 15/0/0/0",
                     count, ovf, busy, done);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_down_auto();
        enb = 1'b1;
        begin_run(15, 1'b0, 1'b1);
        checks++;
        if ({count, ovf, busy} !== {16'd15, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL down_start got count=%0d ovf=%0b busy=%0b want 15/0/1", count, ovf, busy);
        end
        for (int k = 1; k <= 40; k++) begin
            cyc();
            checks++;
            if ({count, ovf} !== {WIDTH'(15 - (k % 16)), (k % 16) == 0}) begin
                errors++;
                $display("FAIL down_auto k=%0d got count=%0d ovf=%0b want %0d/%0b",
                         k, count, ovf, 15 - (k % 16), (k % 16) == 0);
            end
        end
        go_idle();
    endtask

    task automatic test_up_oneshot();
        int ec [6];
        bit eo [6];
        bit eb [6];
        bit ed [6];
        ec = '{0, 1, 2, 3, 0, 0};
        eo = '{0, 0, 0, 0, 1, 0};
        eb = '{1, 1, 1, 1, 0, 0};
        ed = '{0, 0, 0, 0, 1, 1};
        enb = 1'b1;
        begin_run(3, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            checks++;
            if ({count, ovf, busy, done} !== {WIDTH'(ec[k]), eo[k], eb[k], ed[k]}) begin
                errors++;
                $display("FAIL up_oneshot k=%0d got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                         k, count, ovf, busy, done, ec[k], eo[k], eb[k], ed[k]);
            end
        end
        begin_run(3, 1'b1, 1'b0);
        checks++;
        if ({count, busy, done} !== {16'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL oneshot_restart got count=%0d busy=%0b done=%0b want 0/1/0", count, busy, done);
        end
        go_idle();
    endtask

    task automatic test_zero_load();
        bit pat [4];
        pat = '{1, 1, 0, 1};
        begin_run(0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            enb = pat[k];
            cyc();
            checks++;
            if ({count, ovf} !== {16'd0, pat[k]}) begin
                errors++;
                $display("FAIL zero_load k=%0d got count=%0d ovf=%0b want 0/%0b", k, count, ovf, pat[k]);
            end
        end
        enb = 1'b1;
        go_idle();
    endtask

    task automatic test_stop();
        enb = 1'b1;
        begin_run(15, 1'b0, 1'b1);
        repeat (8) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if ({count, ovf, busy} !== {16'd7, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop_hold got count=%0d ovf=%0b busy=%0b want 7/0/0", count, ovf, busy);
        end
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        checks++;
        if ({count, busy} !== {16'd7, 1'b0}) begin
            errors++;
            $display("FAIL start_stop_idle got count=%0d busy=%0b want 7/0", count, busy);
        end
        begin_run(2, 1'b0, 1'b1);
        repeat (2) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if ({count, ovf, busy} !== {16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop_terminal got count=%0d ovf=%0b busy=%0b want 0/0/0", count, ovf, busy);
        end
    endtask

    task automatic test_restart();
        enb = 1'b1;
        begin_run(15, 1'b0, 1'b1);
        repeat (3) cyc();
        load_val = 16'd5; dir = 1'b1; mode_auto = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if ({count, busy} !== {16'd0, 1'b1}) begin
            errors++;
            $display("FAIL restart got count=%0d busy=%0b want 0/1", count, busy);
        end
        load_val = 16'd1; dir = 1'b0; mode_auto = 1'b1;
        repeat (5) cyc();
        checks++;
        if (count !== 16'd5) begin
            errors++;
            $display("FAIL midrun_cfg got count=%0d want 5", count);
        end
        cyc();
        checks++;
        if ({count, ovf, busy, done} !== {16'd0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL restart_done got %0d/%0b/%0b/%0b want 0/1/0/1", count, ovf, busy, done);
        end
        go_idle();
    endtask

`ifdef COUNTER_DIV_PRESCALE_EN
    task automatic test_prescale();
        enb = 1'b1;
        prescale = 4'd2;
        begin_run(3, 1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            cyc();
            checks++;
            if ({count, ovf} !== {WIDTH'(3 - ((k / 3) % 4)), (k % 12) == 0}) begin
                errors++;
                $display("FAIL prescale k=%0d got count=%0d ovf=%0b want %0d/%0b",
                         k, count, ovf, 3 - ((k / 3) % 4), (k % 12) == 0);
            end
        end
        begin_run(3, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            checks++;
            if (count !== ((k == 3) ? 16'd2 : 16'd3)) begin
                errors++;
                $display("FAIL prescale_restart k=%0d got count=%0d want %0d", k, count, (k == 3) ? 2 : 3);
            end
        end
        go_idle();
    endtask
`endif

    task automatic test_random();
        int mc;
        for (int i = 0; i < 3000; i++) begin
            enb       = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 39) == 0);
            stop      = ($urandom_range(0, 59) == 0);
            load_val  = WIDTH'($urandom_range(0, 9));
            dir       = $urandom_range(0, 1) == 1;
            mode_auto = $urandom_range(0, 1) == 1;
`ifdef COUNTER_DIV_PRESCALE_EN
            prescale  = 4'($urandom_range(0, 2));
`endif
            cyc();
            mc = m_count();
            checks++;
            if ({count, ovf, busy, done} !== {mc[WIDTH-1:0], m_ovf, m_run, m_done}) begin
                errors++;
                $display("FAIL random i=%0d got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                         i, count, ovf, busy, done, mc, m_ovf, m_run, m_done);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_down_auto();
        test_up_oneshot();
        test_zero_load();
        test_stop();
        test_restart();
`ifdef COUNTER_DIV_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
